// File: rtl/lut_cfg_pkg.sv
// Shared types for the serial LUT configuration loader.
// Holds the FSM state encoding and table sizing helper.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_e;

    // Total bits held by a LUT with 2**in_w entries of out_w bits.
    function automatic int table_bits(input int in_w, input int out_w);
        return (2 ** in_w) * out_w;
    endfunction

endpackage

// File: rtl/lut_cfg_loader_if.sv
// Host-side word handshake into the LUT loader.
// The master presents a table entry; the slave (loader) accepts on valid && ready.
interface lut_cfg_loader_if #(parameter int OUT_WIDTH = 8);

    logic [OUT_WIDTH-1:0] wr_data;
    logic                 wr_valid;
    logic                 wr_ready;

    modport master (output wr_data, output wr_valid, input  wr_ready);
    modport slave  (input  wr_data, input  wr_valid, output wr_ready);

endinterface

// File: rtl/lut_cfg_serializer.sv
// Parallel-to-serial shifter for one LUT entry: holds the word, emits it
// MSB-first on sd_o with scs_n_o low for exactly OUT_WIDTH cycles.
module lut_cfg_serializer #(
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic                 clr_i,
    input  logic [OUT_WIDTH-1:0] word_i,
    output logic                 sd_o,
    output logic                 scs_n_o,
    output logic                 last_bit_o
);

    localparam int BW = $clog2(OUT_WIDTH);

    logic [OUT_WIDTH-1:0] hold_q;
    logic [BW-1:0]        bit_cnt_q;
    logic                 scs_n_q;

    // sd comes straight off the hold register MSB, so it is glitch-free
    // and lines up with scs_n for the LUT's next sampling edge.
    assign sd_o       = hold_q[OUT_WIDTH-1];
    assign scs_n_o    = scs_n_q;
    assign last_bit_o = shift_i && (bit_cnt_q == BW'(OUT_WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            bit_cnt_q <= '0;
            scs_n_q   <= 1'b1;
        end else if (clr_i) begin
            hold_q    <= '0;
            bit_cnt_q <= '0;
            scs_n_q   <= 1'b1;
        end else if (load_i) begin
            hold_q    <= word_i;
            bit_cnt_q <= '0;
            scs_n_q   <= 1'b0;
        end else if (shift_i) begin
            hold_q <= {hold_q[OUT_WIDTH-2:0], 1'b0};
            if (last_bit_o) begin
                scs_n_q <= 1'b1;
            end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lut_cfg_loader.sv
// Load sequencer for the serial-load LUT: accepts 2**IN_WIDTH entries
// (highest index first), serializes each, and flags a resident table.
module lut_cfg_loader
    import lut_cfg_pkg::*;
#(
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                abort_i,
    lut_cfg_loader_if.slave     wr,
    output logic                sd_o,
    output logic                scs_n_o,
    output logic                busy_o,
    output logic                table_valid_o,
    output logic                done_o
);

    state_e              state_q;
    logic [IN_WIDTH-1:0] word_cnt_q;
    logic                wr_ready_q;
    logic                busy_q;
    logic                table_valid_q;
    logic                done_q;

    logic                in_load;
    logic                load;
    logic                shift;
    logic                clr;
    logic                last_bit;

    assign in_load = (state_q == WAIT_WORD) || (state_q == SHIFT);
    assign clr     = in_load && abort_i;
    assign load    = (state_q == WAIT_WORD) && wr.wr_valid && wr_ready_q && !abort_i;
    assign shift   = (state_q == SHIFT) && !abort_i;

    assign wr.wr_ready     = wr_ready_q;
    assign busy_o          = busy_q;
    assign table_valid_o   = table_valid_q;
    assign done_o          = done_q;

    lut_cfg_serializer #(.OUT_WIDTH(OUT_WIDTH)) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .shift_i    (shift),
        .clr_i      (clr),
        .word_i     (wr.wr_data),
        .sd_o       (sd_o),
        .scs_n_o    (scs_n_o),
        .last_bit_o (last_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            wr_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            table_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i && !abort_i) begin
                        state_q       <= WAIT_WORD;
                        busy_q        <= 1'b1;
                        table_valid_q <= 1'b0;
                        word_cnt_q    <= '0;
                        wr_ready_q    <= 1'b1;
                    end
                end
                WAIT_WORD: begin
                    if (abort_i) begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        table_valid_q <= 1'b0;
                        wr_ready_q    <= 1'b0;
                    end else if (load) begin
                        state_q    <= SHIFT;
                        wr_ready_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (abort_i) begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        table_valid_q <= 1'b0;
                    end else if (last_bit) begin
                        if (word_cnt_q == '1) begin
                            state_q       <= DONE;
                            done_q        <= 1'b1;
                            table_valid_q <= 1'b1;
                            busy_q        <= 1'b0;
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                            state_q    <= WAIT_WORD;
                            wr_ready_q <= 1'b1;
                        end
                    end
                end
                // start arriving here is deliberately dropped
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed bench for lut_cfg_loader with a behavioural serial-load LUT model.
module tb_lut_cfg_loader;
    import lut_cfg_pkg::*;

    localparam int IW = 2;
    localparam int OW = 8;
    localparam int TB = table_bits(IW, OW);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0;
    logic abort_i = 1'b0;
    logic sd_o, scs_n_o, busy_o, table_valid_o, done_o;

    lut_cfg_loader_if #(.OUT_WIDTH(OW)) wr_if();

    lut_cfg_loader #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .wr            (wr_if),
        .sd_o          (sd_o),
        .scs_n_o       (scs_n_o),
        .busy_o        (busy_o),
        .table_valid_o (table_valid_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    // Serial-load LUT: shifts sd in while cs_n is low, sampled one edge after drive.
    logic [TB-1:0] lut_q;
    int scs_low = 0;
    int done_cnt = 0;
    int cyc = 0;
    int done_at = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lut_q <= '0;
        else if (!scs_n_o) lut_q <= {lut_q[TB-2:0], sd_o};
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!scs_n_o) scs_low = scs_low + 1;
    end

    always @(negedge clk) begin
        if (done_o) begin
            done_cnt = done_cnt + 1;
            if (done_at < 0) done_at = cyc;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] words [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!wr_if.wr_ready && k < 100) begin tick(); k++; end
        if (k >= 100) chk({tag, "_timeout"}, 32'(k), 32'(0));
    endtask

    // Full load; gap = idle cycles inserted while the loader waits for a word.
    task automatic load_table(input int gap, input bit start_mid, input string tag);
        int k;
        int s;
        done_cnt = 0;
        done_at  = -1;
        scs_low  = 0;
        start_i = 1'b1;
        s = cyc;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_ready(tag);
            for (int g = 0; g < gap; g++) begin
                if (g == 1) begin
                    chk({tag, "_gap_scs_n"}, 32'(scs_n_o), 32'(1));
                    chk({tag, "_gap_ready"}, 32'(wr_if.wr_ready), 32'(1));
                end
                tick();
            end
            wr_if.wr_data  = words[i];
            wr_if.wr_valid = 1'b1;
            tick();
            wr_if.wr_valid = 1'b0;
            if (start_mid && i == 1) begin
                start_i = 1'b1;
                tick();
                start_i = 1'b0;
            end
        end
        k = 0;
        while (done_at < 0 && k < 100) begin tick(); k++; end
        if (k >= 100) chk({tag, "_done_timeout"}, 32'(k), 32'(0));
        if (gap == 0) chk({tag, "_latency"}, 32'(done_at - s), 32'(37));
        tick();
        chk({tag, "_lut"}, lut_q, 32'hA53CFF01);
        chk({tag, "_scs_low"}, 32'(scs_low), 32'(32));
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(1));
        chk({tag, "_tvalid"}, 32'(table_valid_o), 32'(1));
        chk({tag, "_busy"}, 32'(busy_o), 32'(0));
    endtask

    initial begin
        logic [OW-1:0] exp_rd [4];
        exp_rd = '{8'h01, 8'hFF, 8'h3C, 8'hA5};
        wr_if.wr_data  = '0;
        wr_if.wr_valid = 1'b0;
        tick(); tick();
        chk("rst_ready", 32'(wr_if.wr_ready), 32'(0));
        chk("rst_sd", 32'(sd_o), 32'(0));
        chk("rst_scs_n", 32'(scs_n_o), 32'(1));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_tvalid", 32'(table_valid_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        rst_n = 1'b1;
        tick();

        // wr_valid in IDLE must be ignored
        scs_low = 0;
        wr_if.wr_data  = 8'h55;
        wr_if.wr_valid = 1'b1;
        tick(); tick(); tick();
        chk("idle_ready", 32'(wr_if.wr_ready), 32'(0));
        chk("idle_busy", 32'(busy_o), 32'(0));
        chk("idle_noshift", 32'(scs_low), 32'(0));
        wr_if.wr_valid = 1'b0;
        tick();

        load_table(0, 1'b0, "basic");
        for (int s = 3; s >= 0; s--)
            chk($sformatf("rd_sel%0d", s), 32'(lut_q[s*OW +: OW]), 32'(exp_rd[s]));

        load_table(3, 1'b0, "bp");
        load_table(0, 1'b1, "midstart");

        // Abort after 12 shifted bits
        done_cnt = 0;
        scs_low  = 0;
        start_i = 1'b1; tick(); start_i = 1'b0;
        wait_ready("ab");
        wr_if.wr_data = 8'hA5; wr_if.wr_valid = 1'b1; tick(); wr_if.wr_valid = 1'b0;
        wait_ready("ab");
        wr_if.wr_data = 8'h3C; wr_if.wr_valid = 1'b1; tick(); wr_if.wr_valid = 1'b0;
        tick(); tick(); tick();
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        chk("ab_bits", 32'(scs_low), 32'(12));
        chk("ab_scs_n", 32'(scs_n_o), 32'(1));
        chk("ab_busy", 32'(busy_o), 32'(0));
        chk("ab_tvalid", 32'(table_valid_o), 32'(0));
        chk("ab_ready", 32'(wr_if.wr_ready), 32'(0));
        tick(); tick(); tick();
        chk("ab_nodone", 32'(done_cnt), 32'(0));
        load_table(0, 1'b0, "postab");

        // Asynchronous reset mid-SHIFT
        start_i = 1'b1; tick(); start_i = 1'b0;
        wait_ready("rs");
        wr_if.wr_data = 8'hFF; wr_if.wr_valid = 1'b1; tick(); wr_if.wr_valid = 1'b0;
        tick(); tick();
        chk("rs_pre_busy", 32'(busy_o), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rs_scs_n", 32'(scs_n_o), 32'(1));
        chk("rs_busy", 32'(busy_o), 32'(0));
        chk("rs_tvalid", 32'(table_valid_o), 32'(0));
        chk("rs_ready", 32'(wr_if.wr_ready), 32'(0));
        tick(); tick();
        rst_n = 1'b1;
        tick();
        for (int s = 0; s < 4; s++)
            chk($sformatf("rs_sel%0d", s), 32'(lut_q[s*OW +: OW]), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lut_cfg_loader.md
Name: lut_cfg_loader

Overview:
Configuration sequencer for the serial-load LUT (shift-register table plus combinational select). It accepts table entries as parallel words over a valid/ready handshake and serializes them MSB-first onto the LUT's d/cs_n pins. It tracks word and bit counts and flags when a complete table is resident. The block sits between the host-side config path and the serial_load_lut instance and shares that instance's clock and reset.

Parameters:
IN_WIDTH, 2, LUT select width; the table holds 2**IN_WIDTH entries.
OUT_WIDTH, 8, LUT entry width in bits.
(derived) TABLE_BITS = 2**IN_WIDTH*OUT_WIDTH, 32 at the defaults.

Ports:
clk  in  1  the single clock; all state updates on the rising edge.
rst_n  in  1  reset, asynchronous and active-low.
start  in  1  1-cycle request to begin a full table load.
abort  in  1  cancels a load in progress.
wr_data  in  OUT_WIDTH  table entry word.
wr_valid  in  1  wr_data is valid.
wr_ready  out  1  loader will accept a word this cycle.
sd  out  1  serial data to the LUT's d pin.
scs_n  out  1  shift enable to the LUT's cs_n pin; active low.
busy  out  1  a load is in progress.
table_valid  out  1  the LUT holds a complete, unaborted table.
done  out  1  1-cycle pulse when a load completes.

Behaviour:
- Reset values: state IDLE, wr_ready=0, sd=0, scs_n=1, busy=0, table_valid=0, done=0, counters=0, holding register=0.
- All outputs are registered. The LUT samples sd/scs_n on the clk edge after the one that drives them.
- Entry order: entries are presented from the highest index down to 0 (2**IN_WIDTH-1 first). Each entry is sent MSB-first. After a full load, entry i occupies LUT bits [(i+1)*OUT_WIDTH-1 -: OUT_WIDTH].
- State IDLE:
  - wr_ready=0; wr_valid is ignored.
  - start=1 moves to WAIT_WORD, sets busy=1, clears table_valid, and zeroes word_cnt.
- State WAIT_WORD:
  - wr_ready=1 and scs_n=1.
  - On wr_valid&&wr_ready: capture wr_data into hold, set bit_cnt=0, go to SHIFT.
  - wr_valid=0 stalls the state indefinitely with scs_n held high, so the LUT contents are frozen.
- State SHIFT:
  - wr_ready=0, scs_n=0, sd=hold[OUT_WIDTH-1].
  - hold shifts left by 1 each cycle.
  - scs_n stays low for exactly OUT_WIDTH consecutive cycles per word.
  - On the last bit: if word_cnt==2**IN_WIDTH-1, go to DONE; otherwise increment word_cnt and return to WAIT_WORD (one-cycle bubble between words).
- State DONE (1 cycle): scs_n=1, done=1, table_valid=1, busy=0, then IDLE.
- Minimum load time from the start edge to the done pulse: 2**IN_WIDTH*(OUT_WIDTH+1)+1 cycles (37 at the defaults).
- start while busy is ignored. start in the same cycle as DONE is also ignored.
- abort (any busy state):
  - Next cycle: IDLE, scs_n=1, busy=0, table_valid=0, no done pulse.
  - The partially shifted LUT contents are undefined to the user.
  - abort has priority over wr_valid and start in the same cycle.
- rst_n asserted mid-load forces all outputs to their reset values immediately (asynchronous). The LUT is reset by the same rst_n.
- Counter widths: word_cnt is IN_WIDTH bits, bit_cnt is $clog2(OUT_WIDTH) bits. Neither counter wraps in normal operation, because the terminal counts exit the state.

Decomposition:
- Package lut_cfg_pkg: state enum (IDLE, WAIT_WORD, SHIFT, DONE) and a TABLE_BITS helper function.
- One sub-module, lut_cfg_serializer: hold register, bit_cnt, sd/scs_n generation, last_bit flag.
- The FSM and word counter stay in lut_cfg_loader.

Test Plan:
- Basic load: start, then words 0xA5, 0x3C, 0xFF, 0x01 back-to-back → shift-register model = 0xA53CFF01; scs_n low for exactly 32 cycles total; done pulses once 37 cycles after start; table_valid=1.
- Backpressure: same words with 3 idle cycles between each wr_valid → scs_n high during gaps, wr_ready high while waiting, final contents 0xA53CFF01.
- Abort after 12 shifted bits → next cycle scs_n=1, busy=0, table_valid=0, no done pulse; a subsequent full load succeeds.
- Reset mid-SHIFT (rst_n low for 2 cycles) → scs_n=1, busy=0, table_valid=0 immediately; the LUT reads 0x00 for all sel.
- Ignored inputs:
  - wr_valid=1 in IDLE → wr_ready=0, no shifting.
  - start pulsed during a load → load proceeds unchanged, single done pulse.
- Readback: after the basic load, drive sel=3,2,1,0 on the LUT → out=0xA5, 0x3C, 0xFF, 0x01.
